// File: rtl/te_retire_aggregator.sv
// Multi-lane retirement aggregator: groups retired instructions into E-trace blocks
// and queues them in a small FIFO toward the trace encoder.
module te_retire_aggregator #(
  parameter int unsigned NRET        = 2,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ITYPE_LEN   = 3,
  parameter int unsigned IRETIRE_LEN = 32,
  parameter int unsigned CAUSE_LEN   = 5,
  parameter int unsigned PRIV_LEN    = 2,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NRET-1:0]             valid_i,
  input  logic [NRET*XLEN-1:0]        pc_i,
  input  logic [NRET-1:0]             compressed_i,
  input  logic [NRET*ITYPE_LEN-1:0]   itype_i,
  input  logic [NRET*CAUSE_LEN-1:0]   cause_i,
  input  logic [NRET*XLEN-1:0]        tval_i,
  input  logic [NRET*PRIV_LEN-1:0]    priv_i,
  input  logic                        flush_i,
  output logic                        ready_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [XLEN-1:0]             iaddr_o,
  output logic [IRETIRE_LEN-1:0]      iretire_o,
  output logic                        ilastsize_o,
  output logic [ITYPE_LEN-1:0]        itype_o,
  output logic [CAUSE_LEN-1:0]        cause_o,
  output logic [XLEN-1:0]             tval_o,
  output logic [PRIV_LEN-1:0]         priv_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW = $clog2(NRET + 1);
  localparam int unsigned OW = $clog2(DEPTH + 1);

  localparam logic [IRETIRE_LEN-1:0] IR_ONE = IRETIRE_LEN'(1);
  localparam logic [IRETIRE_LEN-1:0] IR_TWO = IRETIRE_LEN'(2);
  localparam logic [IRETIRE_LEN-1:0] SAT_TH = {IRETIRE_LEN{1'b1}} - IR_TWO;
  localparam logic [OW-1:0]          OCC_READY = OW'(DEPTH - NRET);

  typedef struct packed {
    logic [XLEN-1:0]        iaddr;
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
  } rec_t;

  function automatic logic [IRETIRE_LEN-1:0] f_count_add(input logic [IRETIRE_LEN-1:0] c,
                                                         input logic comp);
    return c + (comp ? IR_ONE : IR_TWO);
  endfunction

  // A further 32-bit instruction could overflow the field, so the block closes here.
  function automatic logic f_sat_hit(input logic [IRETIRE_LEN-1:0] c);
    return c > SAT_TH;
  endfunction

  function automatic logic [PW-1:0] f_ptr_add(input logic [PW-1:0] p, input logic [NW-1:0] k);
    int s;
    s = int'(p) + int'(k);
    if (s >= int'(DEPTH)) s = s - int'(DEPTH);
    return PW'(s);
  endfunction

  logic                   r_open;
  logic [XLEN-1:0]        r_iaddr;
  logic [IRETIRE_LEN-1:0] r_cnt;
  logic [PRIV_LEN-1:0]    r_lpriv;
  logic                   r_llast;
  logic [PW-1:0]          r_wr;
  logic [PW-1:0]          r_rd;
  logic [OW-1:0]          r_occ;
  rec_t                   r_mem [DEPTH];

  logic                   w_open;
  logic [XLEN-1:0]        w_iaddr;
  logic [IRETIRE_LEN-1:0] w_cnt;
  logic [PRIV_LEN-1:0]    w_lpriv;
  logic                   w_llast;
  logic [NW-1:0]          w_n;
  rec_t                   w_rec [NRET+1];
  rec_t                   w_head;
  logic                   w_pop;

  assign ready_o = (r_occ <= OCC_READY);
  assign valid_o = (r_occ != '0);
  assign w_pop   = valid_o & ready_i;
  assign w_head  = r_mem[r_rd];

  // Lane walk: emissions are compacted into w_rec[0..w_n-1] in lane order.
  always_comb begin
    w_open  = r_open;
    w_iaddr = r_iaddr;
    w_cnt   = r_cnt;
    w_lpriv = r_lpriv;
    w_llast = r_llast;
    w_n     = '0;
    for (int e = 0; e <= NRET; e++) w_rec[e] = '0;
    if (ready_o) begin
      for (int k = 0; k < NRET; k++) begin
        if (valid_i[k]) begin
          if (!w_open) begin
            w_iaddr = pc_i[k*XLEN +: XLEN];
            w_cnt   = '0;
            w_open  = 1'b1;
          end
          w_cnt   = f_count_add(w_cnt, compressed_i[k]);
          w_llast = ~compressed_i[k];
          w_lpriv = priv_i[k*PRIV_LEN +: PRIV_LEN];
          if (itype_i[k*ITYPE_LEN +: ITYPE_LEN] != '0) begin
            w_rec[w_n] = '{w_iaddr, w_cnt, ~compressed_i[k],
                           itype_i[k*ITYPE_LEN +: ITYPE_LEN],
                           cause_i[k*CAUSE_LEN +: CAUSE_LEN],
                           tval_i[k*XLEN +: XLEN], w_lpriv};
            w_n    = w_n + NW'(1);
            w_open = 1'b0;
          end else if (f_sat_hit(w_cnt)) begin
            w_rec[w_n] = '{w_iaddr, w_cnt, ~compressed_i[k], '0, '0, '0, w_lpriv};
            w_n    = w_n + NW'(1);
            w_open = 1'b0;
          end
        end
      end
      // An open block after the walk implies the last lane did not emit, so w_n < NRET here.
      if (flush_i && w_open) begin
        w_rec[w_n] = '{w_iaddr, w_cnt, w_llast, '0, '0, '0, w_lpriv};
        w_n    = w_n + NW'(1);
        w_open = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int j = 0; j < NRET; j++) begin
      if (NW'(j) < w_n) r_mem[f_ptr_add(r_wr, NW'(j))] <= w_rec[j];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_open  <= 1'b0;
      r_iaddr <= '0;
      r_cnt   <= '0;
      r_lpriv <= '0;
      r_llast <= 1'b0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_occ   <= '0;
    end else begin
      r_open  <= w_open;
      r_iaddr <= w_iaddr;
      r_cnt   <= w_cnt;
      r_lpriv <= w_lpriv;
      r_llast <= w_llast;
      r_wr    <= f_ptr_add(r_wr, w_n);
      if (w_pop) r_rd <= f_ptr_add(r_rd, NW'(1));
      r_occ   <= r_occ + OW'(w_n) - OW'(w_pop);
    end
  end

  // Stale FIFO storage is not reset; masking keeps outputs at zero while empty.
  assign iaddr_o     = valid_o ? w_head.iaddr     : '0;
  assign iretire_o   = valid_o ? w_head.iretire   : '0;
  assign ilastsize_o = valid_o ? w_head.ilastsize : 1'b0;
  assign itype_o     = valid_o ? w_head.itype     : '0;
  assign cause_o     = valid_o ? w_head.cause     : '0;
  assign tval_o      = valid_o ? w_head.tval      : '0;
  assign priv_o      = valid_o ? w_head.priv      : '0;

endmodule

// File: tb/tb_te_retire_aggregator.sv
// Directed bench for te_retire_aggregator (NRET=2, DEPTH=4, IRETIRE_LEN=4 so saturation is reachable).
module tb_te_retire_aggregator;

  localparam int NRET = 2;
  localparam int XLEN = 64;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [1:0]    valid_i;
  logic [127:0]  pc_i;
  logic [1:0]    compressed_i;
  logic [5:0]    itype_i;
  logic [9:0]    cause_i;
  logic [127:0]  tval_i;
  logic [3:0]    priv_i;
  logic          flush_i;
  logic          ready_o;
  logic          valid_o;
  logic          ready_i;
  logic [63:0]   iaddr_o;
  logic [3:0]    iretire_o;
  logic          ilastsize_o;
  logic [2:0]    itype_o;
  logic [4:0]    cause_o;
  logic [63:0]   tval_o;
  logic [1:0]    priv_o;

  int vecs = 0;
  int errs = 0;

  te_retire_aggregator #(
    .NRET(NRET), .XLEN(XLEN), .ITYPE_LEN(3), .IRETIRE_LEN(4),
    .CAUSE_LEN(5), .PRIV_LEN(2), .DEPTH(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i),
    .compressed_i(compressed_i), .itype_i(itype_i), .cause_i(cause_i),
    .tval_i(tval_i), .priv_i(priv_i), .flush_i(flush_i), .ready_o(ready_o),
    .valid_o(valid_o), .ready_i(ready_i), .iaddr_o(iaddr_o), .iretire_o(iretire_o),
    .ilastsize_o(ilastsize_o), .itype_o(itype_o), .cause_o(cause_o),
    .tval_o(tval_o), .priv_o(priv_o)
  );

  always #5 clk_i = ~clk_i;

  // Valid lanes must be a contiguous run starting at lane 0.
  always @(posedge clk_i) begin
    if (!rst_i) assert (((valid_i + 2'd1) & valid_i) == 2'b00)
      else $error("lane contiguity violated: valid_i=%b", valid_i);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_lanes();
    valid_i = '0; pc_i = '0; compressed_i = '0; itype_i = '0;
    cause_i = '0; tval_i = '0; priv_i = '0;
  endtask

  task automatic set_lane(input int k, input logic [63:0] pc, input logic comp,
                          input logic [2:0] it, input logic [4:0] ca,
                          input logic [63:0] tv, input logic [1:0] pr);
    valid_i[k]           = 1'b1;
    pc_i[k*64 +: 64]     = pc;
    compressed_i[k]      = comp;
    itype_i[k*3 +: 3]    = it;
    cause_i[k*5 +: 5]    = ca;
    tval_i[k*64 +: 64]   = tv;
    priv_i[k*2 +: 2]     = pr;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
    vecs++; if (valid_o !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    vecs++; if (iaddr_o !== 64'h0) begin errs++; $display("FAIL reset_iaddr got %h exp 0", iaddr_o); end
    vecs++; if (iretire_o !== 4'h0) begin errs++; $display("FAIL reset_iretire got %h exp 0", iretire_o); end
    vecs++; if (ready_o !== 1'b1) begin errs++; $display("FAIL reset_ready got %b exp 1", ready_o); end
  endtask

  task automatic test_basic();
    set_lane(0, 64'h1000, 1'b0, 3'd0, 5'd0, 64'h0, 2'd3);
    step();
    vecs++; if (valid_o !== 1'b0) begin errs++; $display("FAIL basic_open_valid got %b exp 0", valid_o); end
    clear_lanes();
    set_lane(0, 64'h1004, 1'b1, 3'd4, 5'd0, 64'h0, 2'd3);
    step();
    clear_lanes();
    vecs++; if (valid_o !== 1'b1) begin errs++; $display("FAIL basic_valid got %b exp 1", valid_o); end
    vecs++; if (iaddr_o !== 64'h1000) begin errs++; $display("FAIL basic_iaddr got %h exp 1000", iaddr_o); end
    vecs++; if (iretire_o !== 4'd3) begin errs++; $display("FAIL basic_iretire got %0d exp 3", iretire_o); end
    vecs++; if (ilastsize_o !== 1'b0) begin errs++; $display("FAIL basic_ilastsize got %b exp 0", ilastsize_o); end
    vecs++; if (itype_o !== 3'd4) begin errs++; $display("FAIL basic_itype got %0d exp 4", itype_o); end
    vecs++; if (priv_o !== 2'd3) begin errs++; $display("FAIL basic_priv got %0d exp 3", priv_o); end
    step();
    vecs++; if (valid_o !== 1'b0) begin errs++; $display("FAIL basic_drain got %b exp 0", valid_o); end
  endtask

  task automatic test_two_specials();
    set_lane(0, 64'h2000, 1'b0, 3'd1, 5'd2, 64'hBAD, 2'd1);
    set_lane(1, 64'h3000, 1'b1, 3'd2, 5'd0, 64'h0, 2'd1);
    step();
    clear_lanes();
    vecs++; if (iaddr_o !== 64'h2000) begin errs++; $display("FAIL two_a_iaddr got %h exp 2000", iaddr_o); end
    vecs++; if (iretire_o !== 4'd2) begin errs++; $display("FAIL two_a_iretire got %0d exp 2", iretire_o); end
    vecs++; if (ilastsize_o !== 1'b1) begin errs++; $display("FAIL two_a_ilastsize got %b exp 1", ilastsize_o); end
    vecs++; if (itype_o !== 3'd1) begin errs++; $display("FAIL two_a_itype got %0d exp 1", itype_o); end
    vecs++; if (cause_o !== 5'd2) begin errs++; $display("FAIL two_a_cause got %0d exp 2", cause_o); end
    vecs++; if (tval_o !== 64'hBAD) begin errs++; $display("FAIL two_a_tval got %h exp bad", tval_o); end
    step();
    vecs++; if (iaddr_o !== 64'h3000) begin errs++; $display("FAIL two_b_iaddr got %h exp 3000", iaddr_o); end
    vecs++; if (iretire_o !== 4'd1) begin errs++; $display("FAIL two_b_iretire got %0d exp 1", iretire_o); end
    vecs++; if (ilastsize_o !== 1'b0) begin errs++; $display("FAIL two_b_ilastsize got %b exp 0", ilastsize_o); end
    vecs++; if (itype_o !== 3'd2) begin errs++; $display("FAIL two_b_itype got %0d exp 2", itype_o); end
    vecs++; if (tval_o !== 64'h0) begin errs++; $display("FAIL two_b_tval got %h exp 0", tval_o); end
    step();
    vecs++; if (valid_o !== 1'b0) begin errs++; $display("FAIL two_drain got %b exp 0", valid_o); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 7; i++) begin
      clear_lanes();
      set_lane(0, 64'h400 + 64'(4 * i), 1'b0, 3'd0, 5'd0, 64'h0, 2'd2);
      step();
      if (i == 5) begin
        vecs++; if (valid_o !== 1'b0) begin errs++; $display("FAIL sat_early got %b exp 0", valid_o); end
      end
    end
    clear_lanes();
    vecs++; if (valid_o !== 1'b1) begin errs++; $display("FAIL sat_valid got %b exp 1", valid_o); end
    vecs++; if (iaddr_o !== 64'h400) begin errs++; $display("FAIL sat_iaddr got %h exp 400", iaddr_o); end
    vecs++; if (iretire_o !== 4'd14) begin errs++; $display("FAIL sat_iretire got %0d exp 14", iretire_o); end
    vecs++; if (ilastsize_o !== 1'b1) begin errs++; $display("FAIL sat_ilastsize got %b exp 1", ilastsize_o); end
    vecs++; if (itype_o !== 3'd0) begin errs++; $display("FAIL sat_itype got %0d exp 0", itype_o); end
    vecs++; if (priv_o !== 2'd2) begin errs++; $display("FAIL sat_priv got %0d exp 2", priv_o); end
    // PC continuity is not tracked, so the block opener can reuse 0x418.
    set_lane(0, 64'h418, 1'b0, 3'd0, 5'd0, 64'h0, 2'd2);
    step();
    clear_lanes();
    vecs++; if (valid_o !== 1'b0) begin errs++; $display("FAIL sat_reopen_valid got %b exp 0", valid_o); end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    vecs++; if (iaddr_o !== 64'h418) begin errs++; $display("FAIL sat_new_iaddr got %h exp 418", iaddr_o); end
    vecs++; if (iretire_o !== 4'd2) begin errs++; $display("FAIL sat_new_iretire got %0d exp 2", iretire_o); end
    step();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      clear_lanes();
      set_lane(0, 64'h100 + 64'(2 * i), 1'b1, 3'd0, 5'd0, 64'h0, 2'd2);
      step();
    end
    clear_lanes();
    vecs++; if (valid_o !== 1'b0) begin errs++; $display("FAIL flush_pre got %b exp 0", valid_o); end
    flush_i = 1'b1;
    step();
    vecs++; if (valid_o !== 1'b1) begin errs++; $display("FAIL flush_valid got %b exp 1", valid_o); end
    vecs++; if (iaddr_o !== 64'h100) begin errs++; $display("FAIL flush_iaddr got %h exp 100", iaddr_o); end
    vecs++; if (iretire_o !== 4'd3) begin errs++; $display("FAIL flush_iretire got %0d exp 3", iretire_o); end
    vecs++; if (ilastsize_o !== 1'b0) begin errs++; $display("FAIL flush_ilastsize got %b exp 0", ilastsize_o); end
    vecs++; if (itype_o !== 3'd0) begin errs++; $display("FAIL flush_itype got %0d exp 0", itype_o); end
    vecs++; if (priv_o !== 2'd2) begin errs++; $display("FAIL flush_priv got %0d exp 2", priv_o); end
    step();
    flush_i = 1'b0;
    vecs++; if (valid_o !== 1'b0) begin errs++; $display("FAIL flush_second got %b exp 0", valid_o); end
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0;
    set_lane(0, 64'h700, 1'b0, 3'd2, 5'd0, 64'h0, 2'd0);
    step();
    vecs++; if (ready_o !== 1'b1) begin errs++; $display("FAIL bp_ready_occ1 got %b exp 1", ready_o); end
    clear_lanes();
    set_lane(0, 64'h710, 1'b0, 3'd2, 5'd0, 64'h0, 2'd0);
    step();
    vecs++; if (ready_o !== 1'b1) begin errs++; $display("FAIL bp_ready_occ2 got %b exp 1", ready_o); end
    clear_lanes();
    set_lane(0, 64'h720, 1'b0, 3'd2, 5'd0, 64'h0, 2'd0);
    step();
    vecs++; if (ready_o !== 1'b0) begin errs++; $display("FAIL bp_ready_occ3 got %b exp 0", ready_o); end
    clear_lanes();
    set_lane(0, 64'h730, 1'b1, 3'd5, 5'd0, 64'h0, 2'd0);
    step(); step();
    vecs++; if (ready_o !== 1'b0) begin errs++; $display("FAIL bp_ready_hold got %b exp 0", ready_o); end
    vecs++; if (iaddr_o !== 64'h700) begin errs++; $display("FAIL bp_head_stable got %h exp 700", iaddr_o); end
    vecs++; if (iretire_o !== 4'd2) begin errs++; $display("FAIL bp_head_iretire got %0d exp 2", iretire_o); end
    ready_i = 1'b1;
    step();
    vecs++; if (iaddr_o !== 64'h710) begin errs++; $display("FAIL bp_drain_b got %h exp 710", iaddr_o); end
    vecs++; if (ready_o !== 1'b1) begin errs++; $display("FAIL bp_ready_back got %b exp 1", ready_o); end
    step();
    clear_lanes();
    vecs++; if (iaddr_o !== 64'h720) begin errs++; $display("FAIL bp_drain_c got %h exp 720", iaddr_o); end
    step();
    vecs++; if (iaddr_o !== 64'h730) begin errs++; $display("FAIL bp_drain_d got %h exp 730", iaddr_o); end
    vecs++; if (itype_o !== 3'd5) begin errs++; $display("FAIL bp_drain_d_itype got %0d exp 5", itype_o); end
    vecs++; if (iretire_o !== 4'd1) begin errs++; $display("FAIL bp_drain_d_iretire got %0d exp 1", iretire_o); end
    step();
    vecs++; if (valid_o !== 1'b0) begin errs++; $display("FAIL bp_empty got %b exp 0", valid_o); end
  endtask

  task automatic test_reset_mid();
    set_lane(0, 64'h500, 1'b0, 3'd0, 5'd0, 64'h0, 2'd1);
    step();
    clear_lanes();
    set_lane(0, 64'h504, 1'b0, 3'd0, 5'd0, 64'h0, 2'd1);
    step();
    clear_lanes();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    vecs++; if (valid_o !== 1'b0) begin errs++; $display("FAIL rmid_valid got %b exp 0", valid_o); end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    vecs++; if (valid_o !== 1'b0) begin errs++; $display("FAIL rmid_discard got %b exp 0", valid_o); end
    set_lane(0, 64'h600, 1'b1, 3'd3, 5'd0, 64'h0, 2'd1);
    step();
    clear_lanes();
    vecs++; if (iaddr_o !== 64'h600) begin errs++; $display("FAIL rmid_iaddr got %h exp 600", iaddr_o); end
    vecs++; if (iretire_o !== 4'd1) begin errs++; $display("FAIL rmid_iretire got %0d exp 1", iretire_o); end
    vecs++; if (ilastsize_o !== 1'b0) begin errs++; $display("FAIL rmid_ilastsize got %b exp 0", ilastsize_o); end
    vecs++; if (itype_o !== 3'd3) begin errs++; $display("FAIL rmid_itype got %0d exp 3", itype_o); end
    step();
  endtask

  initial begin
    clear_lanes();
    flush_i = 1'b0;
    ready_i = 1'b1;
    rst_i   = 1'b1;
    test_reset();
    test_basic();
    test_two_specials();
    test_saturation();
    test_flush();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
